// File: rtl/core_op_arbiter_if.sv
// Request/response bundle between two requesters and the shared-core arbiter.
// Latency: none; wires only.
// Backpressure: req_ready per requester on the request side, rsp_ready per requester on the response side.
interface core_op_arbiter_if #(
  parameter int OP_W  = 2,
  parameter int RES_W = 2 * OP_W
);
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [2*OP_W-1:0] req_a;
  logic [2*OP_W-1:0] req_b;
  logic [1:0]        req_op;
  logic [1:0]        rsp_valid;
  logic [1:0]        rsp_ready;
  logic [RES_W-1:0]  rsp_result;

  // Requester side: issues operands, consumes results.
  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_result
  );

  // Arbiter side: grants requests, returns results.
  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_result
  );
endinterface

// File: rtl/core_op_arbiter.sv
// Round-robin sequencer sharing one combinational add/multiply core between two requesters.
// Latency: accept at T, core driven at T+1, result valid at T+2; one op per 3 cycles at best.
// Backpressure: result held in RESP until the owner takes it; no request is granted meanwhile.
module core_op_arbiter #(
  parameter int OP_W  = 2,
  parameter int RES_W = 2 * OP_W,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  core_op_arbiter_if.slave bus,
  output logic [OP_W-1:0]  core_a,
  output logic [OP_W-1:0]  core_b,
  output logic             core_op,
  input  logic [RES_W-1:0] core_result,
  output logic             busy,
  output logic [CNT_W-1:0] done_cnt0,
  output logic [CNT_W-1:0] done_cnt1
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t            state;
  logic              owner;       // requester whose op is in flight
  logic              last_grant;  // requester served most recently; loses the next tie
  logic              grant;
  logic [1:0]        ready;
  logic              accept;
  logic [OP_W-1:0]   sel_a;
  logic [OP_W-1:0]   sel_b;
  logic              sel_op;

  // Pick the requester to serve: the sole valid one, or on a tie the one not served last.
  always_comb begin
    grant = bus.req_valid[1];
    if (bus.req_valid == 2'b11) begin
      grant = ~last_grant;
    end
    ready = 2'b00;
    if (state == IDLE && bus.req_valid[grant]) begin
      ready[grant] = 1'b1;
    end
    accept = |ready;
    sel_a  = grant ? bus.req_a[2*OP_W-1:OP_W] : bus.req_a[OP_W-1:0];
    sel_b  = grant ? bus.req_b[2*OP_W-1:OP_W] : bus.req_b[OP_W-1:0];
    sel_op = bus.req_op[grant];
  end

  assign bus.req_ready = ready;

  // Sequencer: capture on accept, sample the core for one cycle, hold result until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      owner          <= 1'b0;
      last_grant     <= 1'b1;
      core_a         <= '0;
      core_b         <= '0;
      core_op        <= 1'b0;
      bus.rsp_valid  <= 2'b00;
      bus.rsp_result <= '0;
      busy           <= 1'b0;
      done_cnt0      <= '0;
      done_cnt1      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            // Capture registers double as the core drive, so they are live during EXEC.
            core_a  <= sel_a;
            core_b  <= sel_b;
            core_op <= sel_op;
            owner   <= grant;
            busy    <= 1'b1;
            state   <= EXEC;
          end
        end
        EXEC: begin
          bus.rsp_result <= core_result;
          bus.rsp_valid  <= owner ? 2'b10 : 2'b01;
          state          <= RESP;
        end
        RESP: begin
          // Only the owner's ready bit completes the response.
          if (bus.rsp_ready[owner]) begin
            bus.rsp_valid <= 2'b00;
            core_a        <= '0;
            core_b        <= '0;
            core_op       <= 1'b0;
            last_grant    <= owner;
            busy          <= 1'b0;
            state         <= IDLE;
            if (owner) begin
              if (done_cnt1 != {CNT_W{1'b1}}) done_cnt1 <= done_cnt1 + 1'b1;
            end else begin
              if (done_cnt0 != {CNT_W{1'b1}}) done_cnt0 <= done_cnt0 + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_core_op_arbiter.sv
// Scoreboard bench for core_op_arbiter with a behavioural add/multiply core.
// Latency: n/a.
// Backpressure: exercised by holding rsp_ready low on the owner bit.
module tb_core_op_arbiter;
  localparam int OP_W  = 2;
  localparam int RES_W = 2 * OP_W;
  localparam int CNT_W = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst_n;
  logic [OP_W-1:0]  core_a;
  logic [OP_W-1:0]  core_b;
  logic             core_op;
  logic [RES_W-1:0] core_result;
  logic             busy;
  logic [CNT_W-1:0] done_cnt0;
  logic [CNT_W-1:0] done_cnt1;

  core_op_arbiter_if #(.OP_W(OP_W), .RES_W(RES_W)) bus ();

  core_op_arbiter #(.OP_W(OP_W), .RES_W(RES_W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .core_a      (core_a),
    .core_b      (core_b),
    .core_op     (core_op),
    .core_result (core_result),
    .busy        (busy),
    .done_cnt0   (done_cnt0),
    .done_cnt1   (done_cnt1)
  );

  // Behavioural arithmetic core: op=1 add, op=0 multiply.
  assign core_result = core_op ? (RES_W'(core_a) + RES_W'(core_b))
                               : (RES_W'(core_a) * RES_W'(core_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int id;
    int res;
  } exp_t;

  exp_t exp_q[$];
  int   exp_cnt[2];
  int   pass_cnt = 0;
  int   chk_cnt  = 0;

  task automatic check(input string name, input int act, input int req);
    chk_cnt++;
    if (act == req) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
  endtask

  task automatic push(input int id, input int res);
    exp_t e;
    e.id  = id;
    e.res = res;
    exp_q.push_back(e);
  endtask

  // Monitor: every completed response handshake is matched against the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.rsp_valid == 2'b11) check("rsp_onehot", 3, 1);
      for (int i = 0; i < 2; i++) begin
        if (bus.rsp_valid[i] && bus.rsp_ready[i]) begin
          if (exp_q.size() == 0) begin
            check("unexpected_rsp", i, -1);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("rsp_owner", i, e.id);
            check("rsp_result", int'(bus.rsp_result), e.res);
            if (exp_cnt[i] < CNT_MAX) exp_cnt[i]++;
          end
        end
      end
    end
  end

  task automatic set_req(input int id, input int a, input int b, input int op);
    bus.req_a[id*OP_W +: OP_W] = OP_W'(a);
    bus.req_b[id*OP_W +: OP_W] = OP_W'(b);
    bus.req_op[id]             = op[0];
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check("idle_timeout", 0, 1);
  endtask

  task automatic check_cnts(input string tag);
    check({tag, "_cnt0"}, int'(done_cnt0), exp_cnt[0]);
    check({tag, "_cnt1"}, int'(done_cnt1), exp_cnt[1]);
  endtask

  // Single request from one requester, waits until it completes.
  task automatic issue(input int id, input int a, input int b, input int op, input int res);
    bit ok = 0;
    @(posedge clk); #1;
    set_req(id, a, b, op);
    bus.req_valid[id] = 1'b1;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (bus.req_ready[id]) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      check("grant_timeout", id, -1);
    end else begin
      push(id, res);
    end
    @(posedge clk); #1;
    bus.req_valid[id] = 1'b0;
    wait_idle();
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    exp_cnt[0] = 0;
    exp_cnt[1] = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Both requesters valid at once: requester 0 first, requester 1 exactly 3 cycles later.
  task automatic contend_round(input string tag);
    int  n;
    bit  ok = 0;
    @(posedge clk); #1;
    set_req(0, 2, 1, 1);
    set_req(1, 3, 2, 0);
    bus.req_valid = 2'b11;
    @(negedge clk);
    check({tag, "_first_grant"}, int'(bus.req_ready), 1);
    push(0, 3);
    @(posedge clk); #1;
    bus.req_valid[0] = 1'b0;
    for (n = 1; n < 30; n++) begin
      @(negedge clk);
      if (bus.req_ready != 2'b00) begin
        ok = 1;
        break;
      end
    end
    check({tag, "_second_seen"}, int'(ok), 1);
    check({tag, "_second_grant"}, int'(bus.req_ready), 2);
    check({tag, "_second_delay"}, n, 3);
    push(1, 6);
    @(posedge clk); #1;
    bus.req_valid[1] = 1'b0;
    wait_idle();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1);
  end

  initial begin : stim
    rst_n         = 1'b0;
    bus.req_valid = 2'b00;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_op    = 2'b00;
    bus.rsp_ready = 2'b11;
    exp_cnt[0]    = 0;
    exp_cnt[1]    = 0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", int'(bus.req_ready), 0);
    check("rst_rsp_valid", int'(bus.rsp_valid), 0);
    check("rst_rsp_result", int'(bus.rsp_result), 0);
    check("rst_core_a", int'(core_a), 0);
    check("rst_busy", int'(busy), 0);
    check_cnts("rst");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single multiply 3*3 with cycle-exact timing
    @(posedge clk); #1;
    set_req(0, 3, 3, 0);
    bus.req_valid = 2'b01;
    @(negedge clk);
    check("mul_ready_T", int'(bus.req_ready), 1);
    push(0, 9);
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    @(negedge clk);
    check("mul_core_a_T1", int'(core_a), 3);
    check("mul_core_b_T1", int'(core_b), 3);
    check("mul_core_op_T1", int'(core_op), 0);
    check("mul_busy_T1", int'(busy), 1);
    check("mul_no_rsp_T1", int'(bus.rsp_valid), 0);
    @(negedge clk);
    check("mul_rsp_valid_T2", int'(bus.rsp_valid), 1);
    check("mul_rsp_result_T2", int'(bus.rsp_result), 9);
    @(negedge clk);
    check("mul_busy_T3", int'(busy), 0);
    check("mul_core_a_T3", int'(core_a), 0);
    check("mul_done_cnt0", int'(done_cnt0), 1);

    // Contention after a fresh reset: grants alternate 0,1,0,1
    apply_reset();
    contend_round("cont1");
    contend_round("cont2");
    check_cnts("cont");

    // Backpressure: owner is requester 1, non-owner ready bit high, requester 0 waiting
    @(posedge clk); #1;
    bus.rsp_ready = 2'b01;
    set_req(1, 1, 2, 1);
    bus.req_valid = 2'b10;
    @(negedge clk);
    check("bp_grant1", int'(bus.req_ready), 2);
    push(1, 3);
    @(posedge clk); #1;
    set_req(0, 3, 3, 1);
    bus.req_valid = 2'b01;
    @(negedge clk);
    check("bp_exec_no_ready", int'(bus.req_ready), 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_rsp_valid", int'(bus.rsp_valid), 2);
      check("bp_rsp_result", int'(bus.rsp_result), 3);
      check("bp_req_ready", int'(bus.req_ready), 0);
      check("bp_busy", int'(busy), 1);
    end
    @(posedge clk); #1;
    bus.rsp_ready = 2'b11;
    @(negedge clk);
    @(negedge clk);
    check("bp_release_busy", int'(busy), 0);
    check("bp_release_grant0", int'(bus.req_ready), 1);
    push(0, 6);
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    wait_idle();
    check_cnts("bp");

    // Edge operands
    issue(0, 3, 3, 1, 6);
    issue(1, 0, 3, 0, 0);
    issue(0, 2, 2, 0, 4);
    check_cnts("edge");

    // Reset during EXEC discards the op
    @(posedge clk); #1;
    set_req(0, 2, 2, 0);
    bus.req_valid = 2'b01;
    @(negedge clk);
    check("rmid_ready", int'(bus.req_ready), 1);
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    #2;
    rst_n = 1'b0;
    exp_cnt[0] = 0;
    exp_cnt[1] = 0;
    #1;
    check("rmid_rsp_valid", int'(bus.rsp_valid), 0);
    check("rmid_rsp_result", int'(bus.rsp_result), 0);
    check("rmid_core_a", int'(core_a), 0);
    check("rmid_core_b", int'(core_b), 0);
    check("rmid_busy", int'(busy), 0);
    check_cnts("rmid");
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rmid_no_rsp", int'(bus.rsp_valid), 0);
    end
    check_cnts("rmid_after");

    // Saturation: five completions on requester 1 with a 2-bit counter
    issue(1, 1, 1, 1, 2);
    issue(1, 3, 2, 0, 6);
    issue(1, 2, 3, 1, 5);
    issue(1, 1, 3, 0, 3);
    issue(1, 0, 0, 1, 0);
    check("sat_cnt1", int'(done_cnt1), 3);
    check("sat_cnt0", int'(done_cnt0), 0);
    check_cnts("sat");
    check("final_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/core_op_arbiter.md
Name: core_op_arbiter

Overview:
- Sequencer/arbiter that shares one combinational 2-bit arithmetic core (op=1: add, op=0: multiply, 4-bit result) between two requesters.
- Accepts operand/opcode requests over valid/ready, grants round-robin, drives the core for one cycle, registers the result and returns it over a per-requester response handshake.
- Keeps per-requester completion counters for debug/scan readout.

Parameters:
- OP_W, 2, operand width per input.
- RES_W, 2*OP_W, result width from the core.
- CNT_W, 8, width of each saturating completion counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- req_valid  input  2  bit i: requester i has a request.
- req_ready  output  2  bit i: request i accepted this cycle.
- req_a  input  2*OP_W  operand A; [OP_W-1:0] requester 0, upper half requester 1.
- req_b  input  2*OP_W  operand B, same packing.
- req_op  input  2  opcode per requester: 1 add, 0 multiply.
- rsp_valid  output  2  bit i: result for requester i available.
- rsp_ready  input  2  bit i: requester i takes the result.
- rsp_result  output  RES_W  result, shared bus, qualified by rsp_valid.
- core_a  output  OP_W  operand A to core.
- core_b  output  OP_W  operand B to core.
- core_op  output  1  opcode to core.
- core_result  input  RES_W  combinational core result.
- busy  output  1  high in any state other than IDLE.
- done_cnt0  output  CNT_W  completed responses, requester 0.
- done_cnt1  output  CNT_W  completed responses, requester 1.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, req_ready=0, rsp_valid=0, rsp_result=0, core_a/b/op=0, busy=0, done_cnt0/1=0, last_grant=1 so requester 0 wins first. Any in-flight op is discarded and produces no response.
- FSM has three states: IDLE, EXEC, RESP.
- IDLE:
  - grant = the only valid requester.
  - If both are valid, grant = requester != last_grant.
  - req_ready[grant] = 1 combinationally, only in IDLE; the other bit is 0.
  - On valid&ready, capture a, b, op and owner id, then go to EXEC.
  - With no valid request, stay in IDLE.
- EXEC (exactly 1 cycle):
  - Drive core_a/b/op from the capture registers.
  - Register core_result into rsp_result at the cycle end, then go to RESP.
- RESP:
  - rsp_valid[owner] = 1, held with rsp_result stable until rsp_ready[owner] = 1.
  - On that cycle: go to IDLE, set last_grant = owner, and increment done_cnt[owner] if not at all-ones (saturating).
- core_a/b/op hold the captured values from EXEC through RESP. They return to 0 in IDLE.
- Latency: accept at cycle T -> rsp_valid at T+2 -> earliest next accept at T+3 (with rsp_ready already high at T+2). Peak throughput is 1 op per 3 cycles.
- rsp_ready outside RESP, or on the non-owner bit, is ignored.
- req_valid deassertion before acceptance is legal; the request is simply not granted.
- Requester inputs change only when the request is not pending; the block samples them only at the accept edge.
- Width rule: rsp_result equals core_result bit-for-bit, no truncation at OP_W=2 (max 3*3=9 < 16).
- Simultaneous response completion and a new valid: the new request is arbitrated in the following IDLE cycle, using the updated last_grant.

Test Plan:
- Single multiply: req0 a=3, b=3, op=0 at T -> req_ready[0] at T; core_a=3, core_b=3, core_op=0 at T+1; rsp_valid[0], rsp_result=9 at T+2; done_cnt0=1.
- Contention: both valid after reset (req0 a=2, b=1, op=1; req1 a=3, b=2, op=0) -> req0 served first with 3, then req1 with 6. Both valid again -> req0 granted (last_grant=1). Grants alternate.
- Backpressure: rsp_ready held 0 for 5 cycles in RESP -> rsp_valid and rsp_result stable, req_ready=00, busy=1. The release cycle returns to IDLE.
- Reset mid-op: rst_n low during EXEC -> all outputs 0 immediately. After release, no rsp_valid and counters stay 0.
- Saturation: CNT_W=2, 5 completed req1 ops -> done_cnt1=3, done_cnt0=0.
- Edge operands: op=1 a=3, b=3 -> 6; op=0 a=0, b=3 -> 0; op=0 a=2, b=2 -> 4.
